// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- memory BIST controller driving a small SRAM array.
module mbist_march_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [7:0]        fail_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [2:0]        elem_q, elem_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q;
  logic [DATA_W-1:0] din_q, exp_q;
  logic              busy_q, done_q, fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;
  logic [DATA_W-1:0] fail_exp_q, fail_got_q;
  logic [7:0]        fail_count_q;

  logic two_op, desc, elem_end, last_op, next_we, next_bg;

  // Step to the next March operation; elements 3 and 4 walk addresses downward.
  always_comb begin
    elem_d   = elem_q;
    op_d     = op_q;
    addr_d   = addr_q;
    last_op  = 1'b0;
    two_op   = (elem_q != 3'd0) && (elem_q != 3'd5);
    desc     = (elem_q == 3'd3) || (elem_q == 3'd4);
    elem_end = desc ? (addr_q == '0) : (addr_q == {ADDR_W{1'b1}});
    if (two_op && !op_q) begin
      op_d = 1'b1;
    end else begin
      op_d = 1'b0;
      if (elem_end) begin
        if (elem_q == 3'd5) begin
          last_op = 1'b1;
        end else begin
          elem_d = elem_q + 3'd1;
          addr_d = ((elem_d == 3'd3) || (elem_d == 3'd4)) ? {ADDR_W{1'b1}} : '0;
        end
      end else begin
        addr_d = desc ? addr_q - 1'b1 : addr_q + 1'b1;
      end
    end
    // Op 0 of elements 1..5 is a read; M0 and op 1 of the pairs are writes.
    next_we = (elem_d == 3'd0) || op_d;
    next_bg = next_we ? ((elem_d == 3'd1) || (elem_d == 3'd3))
                      : ((elem_d == 3'd2) || (elem_d == 3'd4));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      elem_q       <= '0;
      op_q         <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      din_q        <= '0;
      exp_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_elem_q  <= '0;
      fail_exp_q   <= '0;
      fail_got_q   <= '0;
      fail_count_q <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!we_q && (mem_dout != exp_q)) begin
            fail_q <= 1'b1;
            if (fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
            if (!fail_q) begin
              fail_addr_q <= addr_q;
              fail_elem_q <= elem_q;
              fail_exp_q  <= exp_q;
              fail_got_q  <= mem_dout;
            end
          end
          if (last_op) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            elem_q  <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            exp_q   <= '0;
          end else begin
            elem_q <= elem_d;
            op_q   <= op_d;
            addr_q <= addr_d;
            we_q   <= next_we;
            din_q  <= next_we ? {DATA_W{next_bg}} : '0;
            exp_q  <= {DATA_W{next_bg}};
          end
        end
        default: begin
          if (start) begin
            state_q      <= S_RUN;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= '0;
            fail_exp_q   <= '0;
            fail_got_q   <= '0;
            fail_count_q <= '0;
            elem_q       <= '0;
            op_q         <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b1;
            din_q        <= '0;
            exp_q        <= '0;
          end
        end
      endcase
    end
  end

  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_we     = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_elem  = fail_elem_q;
  assign fail_exp   = fail_exp_q;
  assign fail_got   = fail_got_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - Directed bench for mbist_march_ctrl with a fault-injecting 4x4 SRAM model.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] mem_addr;
  logic [3:0] mem_din, mem_dout;
  logic       mem_we, busy, done, fail;
  logic [1:0] fail_addr;
  logic [2:0] fail_elem;
  logic [3:0] fail_exp, fail_got;
  logic [7:0] fail_count;

  int passed = 0;
  int total  = 0;
  int fault_mode = 0;  // 0 none, 1 addr1 bit2 SA0, 2 addr3 bit0 SA1, 3 write-1 to addr2 sets addr1 bit3

  logic [3:0] mem [4];
  logic       rec_we   [64];
  logic [1:0] rec_addr [64];
  logic [3:0] rec_din  [64];
  int         run_cycles;
  logic       first_fail, first_done;
  logic [7:0] first_cnt;

  int         nops [6] = '{1, 2, 2, 2, 2, 1};
  logic [1:0] opc  [6][2] = '{'{2'b10, 2'b00}, '{2'b00, 2'b11}, '{2'b01, 2'b10},
                             '{2'b00, 2'b11}, '{2'b01, 2'b10}, '{2'b00, 2'b00}};

  mbist_march_ctrl #(.ADDR_W(2), .DATA_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_exp(fail_exp),
    .fail_got(fail_got), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      if (fault_mode == 3 && mem_addr == 2'd2 && mem_din == 4'hF) mem[1][3] <= 1'b1;
    end
  end

  always_comb begin
    mem_dout = mem[mem_addr];
    if (fault_mode == 1 && mem_addr == 2'd1) mem_dout[2] = 1'b0;
    if (fault_mode == 2 && mem_addr == 2'd3) mem_dout[0] = 1'b1;
  end

  task automatic run_march(input int restart_at);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    run_cycles = 0;
    first_fail = fail;
    first_done = done;
    first_cnt  = fail_count;
    while (busy && run_cycles < 100) begin
      if (run_cycles < 64) begin
        rec_we[run_cycles]   = mem_we;
        rec_addr[run_cycles] = mem_addr;
        rec_din[run_cycles]  = mem_din;
      end
      run_cycles++;
      start = (run_cycles == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, fail, mem_we} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {busy, done, fail, mem_we}); else passed++;
    total++; if ({mem_addr, mem_din} !== 6'h0) $display("FAIL reset_mem_bus got %h exp 00", {mem_addr, mem_din}); else passed++;
    total++; if ({fail_addr, fail_elem, fail_exp, fail_got, fail_count} !== 21'h0) $display("FAIL reset_fail_regs got %h exp 0", {fail_addr, fail_elem, fail_exp, fail_got, fail_count}); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_run();
    int n;
    logic ew;
    logic [1:0] ea;
    logic [3:0] ed;
    fault_mode = 0;
    run_march(-1);
    total++; if (run_cycles !== 40) $display("FAIL clean_busy_cycles got %0d exp 40", run_cycles); else passed++;
    total++; if ({done, busy, mem_we} !== 3'b100) $display("FAIL clean_end_flags got %b exp 100", {done, busy, mem_we}); else passed++;
    total++; if ({mem_addr, mem_din} !== 6'h0) $display("FAIL clean_end_bus got %h exp 00", {mem_addr, mem_din}); else passed++;
    total++; if (fail !== 1'b0 || fail_count !== 8'd0) $display("FAIL clean_fail got fail=%b count=%0d exp 0 0", fail, fail_count); else passed++;
    n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 4; i++) begin
        for (int o = 0; o < nops[e]; o++) begin
          ew = opc[e][o][1];
          ea = (e == 3 || e == 4) ? 2'(3 - i) : 2'(i);
          ed = ew ? {4{opc[e][o][0]}} : 4'h0;
          total++;
          if (rec_we[n] !== ew || rec_addr[n] !== ea || rec_din[n] !== ed)
            $display("FAIL op_seq[%0d] got we=%b addr=%0d din=%h exp we=%b addr=%0d din=%h", n, rec_we[n], rec_addr[n], rec_din[n], ew, ea, ed);
          else passed++;
          n++;
        end
      end
    end
  endtask

  task automatic test_stuck0();
    fault_mode = 1;
    run_march(-1);
    total++; if (run_cycles !== 40 || fail !== 1'b1) $display("FAIL sa0_fail got cycles=%0d fail=%b exp 40 1", run_cycles, fail); else passed++;
    total++; if (fail_elem !== 3'd2 || fail_addr !== 2'd1) $display("FAIL sa0_loc got elem=%0d addr=%0d exp 2 1", fail_elem, fail_addr); else passed++;
    total++; if (fail_exp !== 4'hF || fail_got !== 4'hB) $display("FAIL sa0_data got exp=%h got=%h exp F B", fail_exp, fail_got); else passed++;
    total++; if (fail_count !== 8'd2) $display("FAIL sa0_count got %0d exp 2", fail_count); else passed++;
  endtask

  task automatic test_stuck1();
    fault_mode = 2;
    run_march(-1);
    total++; if (fail_elem !== 3'd1 || fail_addr !== 2'd3) $display("FAIL sa1_loc got elem=%0d addr=%0d exp 1 3", fail_elem, fail_addr); else passed++;
    total++; if (fail_exp !== 4'h0 || fail_got !== 4'h1) $display("FAIL sa1_data got exp=%h got=%h exp 0 1", fail_exp, fail_got); else passed++;
    total++; if (fail_count !== 8'd3 || fail !== 1'b1) $display("FAIL sa1_count got %0d fail=%b exp 3 1", fail_count, fail); else passed++;
  endtask

  task automatic test_coupling();
    fault_mode = 3;
    run_march(-1);
    total++; if (fail !== 1'b1 || fail_elem !== 3'd3 || fail_addr !== 2'd1) $display("FAIL cf_loc got fail=%b elem=%0d addr=%0d exp 1 3 1", fail, fail_elem, fail_addr); else passed++;
    total++; if (fail_exp !== 4'h0 || fail_got !== 4'h8) $display("FAIL cf_data got exp=%h got=%h exp 0 8", fail_exp, fail_got); else passed++;
    fault_mode = 0;
  endtask

  task automatic test_rst_midrun();
    int we_seen;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got %b exp 1", busy); else passed++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if ({busy, done, fail, mem_we, mem_addr, mem_din, fail_count} !== 18'h0) $display("FAIL rst_mid_outputs got %h exp 0", {busy, done, fail, mem_we, mem_addr, mem_din, fail_count}); else passed++;
    we_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we !== 1'b0 || busy !== 1'b0) we_seen++;
    end
    total++; if (we_seen !== 0) $display("FAIL rst_we_quiet got %0d active cycles exp 0", we_seen); else passed++;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_start_together got busy=%b we=%b exp 0 0", busy, mem_we); else passed++;
    run_march(-1);
    total++; if (run_cycles !== 40 || done !== 1'b1 || fail !== 1'b0) $display("FAIL rst_rerun got cycles=%0d done=%b fail=%b exp 40 1 0", run_cycles, done, fail); else passed++;
  endtask

  task automatic test_start_midrun();
    run_march(10);
    total++; if (run_cycles !== 40 || done !== 1'b1) $display("FAIL start_ignored got cycles=%0d done=%b exp 40 1", run_cycles, done); else passed++;
  endtask

  task automatic test_rerun_clears();
    fault_mode = 1;
    run_march(-1);
    total++; if (fail !== 1'b1) $display("FAIL rerun_pre_fail got %b exp 1", fail); else passed++;
    fault_mode = 0;
    run_march(-1);
    total++; if ({first_fail, first_done, first_cnt} !== 10'h0) $display("FAIL rerun_cleared got fail=%b done=%b count=%0d exp 0 0 0", first_fail, first_done, first_cnt); else passed++;
    total++; if (fail !== 1'b0 || fail_count !== 8'd0 || {fail_elem, fail_addr, fail_exp, fail_got} !== 13'h0) $display("FAIL rerun_clean got fail=%b count=%0d regs=%h exp 0 0 0", fail, fail_count, {fail_elem, fail_addr, fail_exp, fail_got}); else passed++;
    total++; if (run_cycles !== 40 || done !== 1'b1) $display("FAIL rerun_done got cycles=%0d done=%b exp 40 1", run_cycles, done); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_run();
    test_stuck0();
    test_stuck1();
    test_coupling();
    test_rst_midrun();
    test_start_midrun();
    test_rerun_clears();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

Memory built-in self-test controller that sits directly upstream of the 4x4 SRAM array and owns its address, write-data and write-enable inputs while a test runs. On a start pulse it executes the March C- algorithm (10N operations, one operation per clock) and compares every read against the expected data background. It reports pass/fail, the first failing location and a failure count.

## Interface
- `ADDR_W`, default 2: SRAM address width; N = 2^ADDR_W words.
- `DATA_W`, default 4: SRAM word width.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: one-cycle request to begin a test; honoured only when not busy.
- `mem_addr` output, ADDR_W: SRAM address.
- `mem_din` output, DATA_W: SRAM write data.
- `mem_we` output, 1: SRAM write enable.
- `mem_dout` input, DATA_W: SRAM read data; combinational from `mem_addr`.
- `busy` output, 1: test in progress.
- `done` output, 1: test finished; level, held until next accepted `start` or `rst`.
- `fail` output, 1: sticky, at least one read mismatch this run.
- `fail_addr` output, ADDR_W: address of first mismatch.
- `fail_elem` output, 3: March element index (0..5) of first mismatch.
- `fail_exp` output, DATA_W: expected word at first mismatch.
- `fail_got` output, DATA_W: `mem_dout` captured at first mismatch.
- `fail_count` output, 8: number of mismatching reads, saturates at 255.

## Operation
- States: IDLE, RUN, DONE. IDLE/DONE --(start)--> RUN; RUN --(last op of M5 at address 0..N-1 complete)--> DONE. `start` in RUN ignored.
- Accepted `start` clears `fail`, `fail_*`, `fail_count`, `done`.
- March C- elements, all-zeros background 0 = {DATA_W{0}}, 1 = {DATA_W{1}}:
  - M0 ascending: w0
  - M1 ascending: r0, w1
  - M2 ascending: r1, w0
  - M3 descending: r0, w1
  - M4 descending: r1, w0
  - M5 ascending: r0
- Two-op elements issue both ops to one address before advancing. Ascending = 0..N-1, descending = N-1..0.
- Counters: element index (3 bits), op index within element (1 bit), address (ADDR_W bits, wraps naturally; wrap marks element end).
- Write op: `mem_we`=1, `mem_din`=background. Read op: `mem_we`=0, `mem_din`=0, expected word registered alongside `mem_addr`.
- Compare: at the rising edge ending a read cycle, `mem_dout` != expected → `fail`=1, `fail_count`+1 (saturating). If this is the first mismatch of the run, latch `fail_addr`, `fail_elem`, `fail_exp`, `fail_got`.
- `fail_*` capture registers hold their values through DONE until the next accepted `start`.

## Timing
- All outputs registered. Reset values: `mem_addr`=0, `mem_din`=0, `mem_we`=0, `busy`=0, `done`=0, `fail`=0, `fail_addr`=0, `fail_elem`=0, `fail_exp`=0, `fail_got`=0, `fail_count`=0; state IDLE.
- `start` sampled at edge k → `busy`=1 and op 0 (M0 w0 @ addr 0) presented in cycle k+1.
- One op per cycle, no stalls: 10N ops (40 for N=4) occupy cycles k+1..k+10N.
- SRAM commits a write at the edge ending its cycle. The controller compares reads at that same edge.
- At edge k+10N+1: `busy`=0, `done`=1, `mem_we`=0, and `mem_addr`/`mem_din` return to 0.
- `start` in the same cycle `done` is high: accepted. `done` clears and a new run begins next cycle.
- `rst` mid-run: at that edge all outputs take reset values, and `mem_we` is 0 from the next cycle. The partial run is discarded.
- `rst` and `start` together: `rst` wins; result is IDLE.

## Test plan
- Fault-free SRAM model, pulse `start` → `busy` high for exactly 40 cycles. `done`=1 on cycle 41. `fail`=0, `fail_count`=0. Write/read op sequence and addresses match the March table.
- Bit 2 of addr 1 stuck-at-0 → `fail`=1, `fail_elem`=2, `fail_addr`=1, `fail_exp`=4'hF, `fail_got`=4'hB, `fail_count`=2.
- Bit 0 of addr 3 stuck-at-1 → `fail_elem`=1, `fail_addr`=3, `fail_exp`=4'h0, `fail_got`=4'h1, `fail_count`=3.
- Coupling fault where a write of 1 to addr 2 flips bit 3 of addr 1 → first mismatch `fail_elem`=3, `fail_addr`=1, `fail_exp`=4'h0, `fail_got`=4'h8.
- `rst` asserted during op 17 → all outputs 0 next cycle, `mem_we` stays 0. A new `start` then completes a clean 40-cycle run.
- `start` pulsed mid-run → ignored, completion still at cycle 41. A second `start` after a failing run → `fail`, `fail_*` and `fail_count` cleared. The fault-free rerun ends with `fail`=0.
